// File: rtl/fp_divider.sv
// IEEE-754 binary32 divider: iterative unpack / special-case / normalise /
// 27-step restoring divide / round-to-nearest-even / pack, one op at a time.
module fp_divider (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   input  logic [31:0] input_b,
   input  logic        input_b_stb,
   output logic [31:0] output_z,
   output logic        output_z_stb
);

   typedef enum logic [3:0] {
      get_ab,
      unpack,
      special_cases,
      normalise_a,
      normalise_b,
      divide_0,
      divide_1,
      divide_2,
      normalise_2,
      round,
      pack,
      put_z
   } state_t;

   state_t state;

   logic [31:0]       a, b, z;
   logic [23:0]       a_m, b_m, z_m;
   logic signed [9:0] a_e, b_e, z_e;
   logic              z_s;
   logic              guard, round_bit, sticky;
   logic [26:0]       q;
   logic [24:0]       rem;
   logic [4:0]        count;

   logic              rem_ge;
   logic [24:0]       rem_next;
   logic              sign_ab;

   always_comb begin
      rem_ge   = rem >= {1'b0, b_m};
      rem_next = rem_ge ? rem - {1'b0, b_m} : rem;
      sign_ab  = a[31] ^ b[31];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= get_ab;
         output_z     <= '0;
         output_z_stb <= 1'b0;
         a            <= '0;
         b            <= '0;
         z            <= '0;
         a_m          <= '0;
         b_m          <= '0;
         z_m          <= '0;
         a_e          <= '0;
         b_e          <= '0;
         z_e          <= '0;
         z_s          <= 1'b0;
         guard        <= 1'b0;
         round_bit    <= 1'b0;
         sticky       <= 1'b0;
         q            <= '0;
         rem          <= '0;
         count        <= '0;
      end else begin
         case (state)
            get_ab: begin
               output_z_stb <= 1'b0;
               if (input_a_stb && input_b_stb) begin
                  a     <= input_a;
                  b     <= input_b;
                  state <= unpack;
               end
            end

            unpack: begin
               a_m   <= {1'b0, a[22:0]};
               b_m   <= {1'b0, b[22:0]};
               a_e   <= $signed({2'b00, a[30:23]}) - 10'sd127;
               b_e   <= $signed({2'b00, b[30:23]}) - 10'sd127;
               state <= special_cases;
            end

            special_cases: begin
               // Exponent 128 is inf/NaN, -127 with zero mantissa is zero.
               if ((a_e == 10'sd128 && a_m != '0) || (b_e == 10'sd128 && b_m != '0)) begin
                  z     <= 32'hFFC0_0000;
                  state <= put_z;
               end else if (a_e == 10'sd128) begin
                  z     <= (b_e == 10'sd128) ? 32'hFFC0_0000 : {sign_ab, 8'hFF, 23'd0};
                  state <= put_z;
               end else if (b_e == 10'sd128) begin
                  z     <= {sign_ab, 31'd0};
                  state <= put_z;
               end else if (a_e == -10'sd127 && a_m == '0) begin
                  z     <= (b_e == -10'sd127 && b_m == '0) ? 32'hFFC0_0000 : {sign_ab, 31'd0};
                  state <= put_z;
               end else if (b_e == -10'sd127 && b_m == '0) begin
                  z     <= {sign_ab, 8'hFF, 23'd0};
                  state <= put_z;
               end else begin
                  if (a_e == -10'sd127) a_e <= -10'sd126;
                  else                  a_m[23] <= 1'b1;
                  if (b_e == -10'sd127) b_e <= -10'sd126;
                  else                  b_m[23] <= 1'b1;
                  state <= normalise_a;
               end
            end

            normalise_a: begin
               if (a_m[23]) begin
                  state <= normalise_b;
               end else begin
                  a_m <= a_m << 1;
                  a_e <= a_e - 10'sd1;
               end
            end

            normalise_b: begin
               if (b_m[23]) begin
                  state <= divide_0;
               end else begin
                  b_m <= b_m << 1;
                  b_e <= b_e - 10'sd1;
               end
            end

            divide_0: begin
               z_s   <= sign_ab;
               z_e   <= a_e - b_e;
               rem   <= {1'b0, a_m};
               q     <= '0;
               count <= '0;
               state <= divide_1;
            end

            divide_1: begin
               q     <= {q[25:0], rem_ge};
               rem   <= {rem_next[23:0], 1'b0};
               count <= count + 5'd1;
               if (count == 5'd26) state <= divide_2;
            end

            divide_2: begin
               if (q[26]) begin
                  z_m       <= q[26:3];
                  guard     <= q[2];
                  round_bit <= q[1];
                  sticky    <= q[0] | (rem != '0);
               end else begin
                  z_e       <= z_e - 10'sd1;
                  z_m       <= q[25:2];
                  guard     <= q[1];
                  round_bit <= q[0];
                  sticky    <= (rem != '0);
               end
               state <= normalise_2;
            end

            normalise_2: begin
               if (z_e < -10'sd126) begin
                  z_e       <= z_e + 10'sd1;
                  z_m       <= z_m >> 1;
                  guard     <= z_m[0];
                  round_bit <= guard;
                  sticky    <= sticky | round_bit;
               end else begin
                  state <= round;
               end
            end

            round: begin
               // Mantissa wrap to zero on carry-out pairs with the exponent bump.
               if (guard && (round_bit || sticky || z_m[0])) begin
                  z_m <= z_m + 24'd1;
                  if (z_m == 24'hFF_FFFF) z_e <= z_e + 10'sd1;
               end
               state <= pack;
            end

            pack: begin
               z[22:0]  <= z_m[22:0];
               z[30:23] <= z_e[7:0] + 8'd127;
               z[31]    <= z_s;
               if (z_e == -10'sd126 && !z_m[23]) z[30:23] <= 8'd0;
               if (z_e > 10'sd127) begin
                  z[22:0]  <= '0;
                  z[30:23] <= 8'hFF;
               end
               state <= put_z;
            end

            put_z: begin
               output_z     <= z;
               output_z_stb <= 1'b1;
               state        <= get_ab;
            end

            default: state <= get_ab;
         endcase
      end
   end

endmodule
